alu_op_issuer: RTL and testbench

//  Command-side master for the 16-bit ALU datapath. It accepts one operation per valid/ready handshake and drives the

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_op_issuer_if.sv | 46 ++++
 rtl/alu_issue_timer.sv | 27 ++
 rtl/alu_op_issuer.sv | 109 ++++++++++
 tb/tb_alu_op_issuer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared widths, opcode constants and FSM state type for the ALU command issuer.
package alu_pkg;

    localparam int unsigned alu_width = 16;
    localparam int unsigned opc_w     = 3;
    localparam int unsigned cnt_w     = 4;

    localparam logic [opc_w-1:0] OPC_0 = 3'd0;
    localparam logic [opc_w-1:0] OPC_1 = 3'd1;
    localparam logic [opc_w-1:0] OPC_2 = 3'd2;
    localparam logic [opc_w-1:0] OPC_3 = 3'd3;
    localparam logic [opc_w-1:0] OPC_4 = 3'd4;
    localparam logic [opc_w-1:0] OPC_5 = 3'd5;
    localparam logic [opc_w-1:0] OPC_6 = 3'd6;
    localparam logic [opc_w-1:0] OPC_7 = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } issuer_state_t;

endpackage

// File: rtl/alu_op_issuer_if.sv
// Command, ALU-drive and response signals of the issuer; master = issuer side, slave = environment side.
interface alu_op_issuer_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OPC_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_n;
    logic [WIDTH-1:0] cmd_m;
    logic [OPC_W-1:0] cmd_opc;
    logic             cmd_c;

    logic [WIDTH-1:0] alu_n;
    logic [WIDTH-1:0] alu_m;
    logic [OPC_W-1:0] alu_opc;
    logic             alu_c;
    logic [WIDTH-1:0] alu_f;
    logic             alu_zer;
    logic             alu_neg;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_f;
    logic             rsp_zer;
    logic             rsp_neg;
    logic             rsp_err;

    modport master (
        input  cmd_valid, cmd_n, cmd_m, cmd_opc, cmd_c,
        output cmd_ready,
        output alu_n, alu_m, alu_opc, alu_c,
        input  alu_f, alu_zer, alu_neg,
        output rsp_valid, rsp_f, rsp_zer, rsp_neg, rsp_err,
        input  rsp_ready
    );

    modport slave (
        output cmd_valid, cmd_n, cmd_m, cmd_opc, cmd_c,
        input  cmd_ready,
        input  alu_n, alu_m, alu_opc, alu_c,
        output alu_f, alu_zer, alu_neg,
        input  rsp_valid, rsp_f, rsp_zer, rsp_neg, rsp_err,
        output rsp_ready
    );

endinterface

// File: rtl/alu_issue_timer.sv
// Loadable down-counter that times how long ALU inputs are held before capture.
module alu_issue_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/alu_op_issuer.sv
// Issues one ALU operation per handshake, captures f/zer/neg after SETTLE cycles and flags inconsistent flags.
// Optional build macro ALU_ISSUER_STATS_EN adds stat_ops/stat_errs response counters.
module alu_op_issuer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = alu_width,
    parameter int unsigned OPC_W  = opc_w,
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    alu_op_issuer_if.master bus
`ifdef ALU_ISSUER_STATS_EN
    ,
    output logic [15:0] stat_ops,
    output logic [15:0] stat_errs
`endif
);

    issuer_state_t state;
    logic          accept;
    logic          timer_zero;
    logic          flag_err;

    assign accept = (state == IDLE) && bus.cmd_valid;

    alu_issue_timer #(.W(cnt_w)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (cnt_w'(SETTLE - 1)),
        .dec      (state == WAIT),
        .zero     (timer_zero)
    );

    always_comb begin
        flag_err = 1'b0;
        if ((bus.alu_zer != (bus.alu_f == '0)) || (bus.alu_neg != bus.alu_f[WIDTH-1])) begin
            flag_err = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.cmd_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.alu_n     <= '0;
            bus.alu_m     <= '0;
            bus.alu_opc   <= '0;
            bus.alu_c     <= 1'b0;
            bus.rsp_f     <= '0;
            bus.rsp_zer   <= 1'b0;
            bus.rsp_neg   <= 1'b0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        bus.alu_n     <= bus.cmd_n;
                        bus.alu_m     <= bus.cmd_m;
                        bus.alu_opc   <= bus.cmd_opc;
                        bus.alu_c     <= bus.cmd_c;
                        bus.cmd_ready <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (timer_zero) begin
                        bus.rsp_f     <= bus.alu_f;
                        bus.rsp_zer   <= bus.alu_zer;
                        bus.rsp_neg   <= bus.alu_neg;
                        bus.rsp_err   <= flag_err;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    // cmd_ready returns with the handshake edge so no command slips into the RESP cycle
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.cmd_ready <= 1'b1;
                    bus.rsp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_ISSUER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops  <= '0;
            stat_errs <= '0;
        end else if ((state == RESP) && bus.rsp_ready) begin
            stat_ops <= stat_ops + 16'd1;
            if (bus.rsp_err) begin
                stat_errs <= stat_errs + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer with a behavioural ALU and zero-flag fault injection.
module tb_alu_op_issuer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic force_zer = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_op_issuer_if #(.WIDTH(16), .OPC_W(3)) bus ();

`ifdef ALU_ISSUER_STATS_EN
    logic [15:0] stat_ops;
    logic [15:0] stat_errs;
`endif

    alu_op_issuer #(.WIDTH(16), .OPC_W(3), .SETTLE(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.master)
`ifdef ALU_ISSUER_STATS_EN
        ,
        .stat_ops  (stat_ops),
        .stat_errs (stat_errs)
`endif
    );

    function automatic logic [15:0] alu_model(input logic [15:0] n, input logic [15:0] m,
                                              input logic [2:0] opc, input logic c);
        case (opc)
            OPC_0:   alu_model = n + m + {15'd0, c};
            OPC_1:   alu_model = n - m;
            OPC_2:   alu_model = n & m;
            OPC_3:   alu_model = n | m;
            OPC_4:   alu_model = n ^ m;
            OPC_5:   alu_model = ~n;
            OPC_6:   alu_model = n << 1;
            default: alu_model = m;
        endcase
    endfunction

    assign bus.alu_f   = alu_model(bus.alu_n, bus.alu_m, bus.alu_opc, bus.alu_c);
    assign bus.alu_zer = force_zer ? 1'b1 : (bus.alu_f == 16'd0);
    assign bus.alu_neg = bus.alu_f[15];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents one command at a negedge; returns #1 after the accepting edge T0.
    task automatic issue(input logic [15:0] n, input logic [15:0] m, input logic [2:0] opc, input logic c);
        int unsigned k;
        k = 0;
        @(negedge clk);
        while (!bus.cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) check("issue_timeout", 32'd0, 32'd1);
        bus.cmd_n     = n;
        bus.cmd_m     = m;
        bus.cmd_opc   = opc;
        bus.cmd_c     = c;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    // Waits for rsp_valid, returns edges waited, leaves rsp_ready low.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!bus.rsp_valid && lat < 50) begin
            @(posedge clk);
            #1 lat++;
        end
        if (lat >= 50) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic take_rsp();
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
    endtask

    task automatic check_rsp(input string tag, input logic [15:0] f, input logic zer,
                             input logic neg, input logic err);
        check({tag, "_f"},   32'(bus.rsp_f),   32'(f));
        check({tag, "_zer"}, 32'(bus.rsp_zer), 32'(zer));
        check({tag, "_neg"}, 32'(bus.rsp_neg), 32'(neg));
        check({tag, "_err"}, 32'(bus.rsp_err), 32'(err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic        seen;
        logic [15:0] hold_f;
        logic [15:0] n, m, f;
        logic [2:0]  opc;
        logic        c;

        bus.cmd_valid = 1'b0;
        bus.cmd_n     = '0;
        bus.cmd_m     = '0;
        bus.cmd_opc   = '0;
        bus.cmd_c     = 1'b0;
        bus.rsp_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_f",     32'(bus.rsp_f),     32'd0);

        // reset during WAIT discards the command
        issue(16'd100, 16'd23, OPC_0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_alu_n",     32'(bus.alu_n),     32'd0);
        check("mid_alu_m",     32'(bus.alu_m),     32'd0);
        check("mid_alu_opc",   32'(bus.alu_opc),   32'd0);
        check("mid_alu_c",     32'(bus.alu_c),     32'd0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        check("mid_no_rsp", 32'(seen), 32'd0);

        // basic add with latency
        issue(16'd8, 16'd3, OPC_0, 1'b0);
        check("basic_ready_low", 32'(bus.cmd_ready), 32'd0);
        check("basic_alu_n",     32'(bus.alu_n),     32'd8);
        wait_rsp(lat);
        check("basic_latency", 32'(lat), 32'd2);
        check_rsp("basic", 16'd11, 1'b0, 1'b0, 1'b0);
        take_rsp();
        check("basic_after_valid", 32'(bus.rsp_valid), 32'd0);
        check("basic_after_ready", 32'(bus.cmd_ready), 32'd1);

        // zero and negative results
        issue(16'hFFFB, 16'd5, OPC_0, 1'b0);
        wait_rsp(lat);
        check_rsp("zero", 16'd0, 1'b1, 1'b0, 1'b0);
        take_rsp();
        issue(16'hFFF8, 16'd3, OPC_0, 1'b0);
        wait_rsp(lat);
        check_rsp("neg", 16'hFFFB, 1'b0, 1'b1, 1'b0);
        take_rsp();

        // backpressure with an ignored second command
        issue(16'd20, 16'd22, OPC_0, 1'b1);
        wait_rsp(lat);
        hold_f = 16'd43;
        bus.cmd_n     = 16'd7;
        bus.cmd_m     = 16'd7;
        bus.cmd_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_f",     32'(bus.rsp_f),     32'(hold_f));
            check("bp_ready", 32'(bus.cmd_ready), 32'd0);
        end
        bus.cmd_valid = 1'b0;
        take_rsp();
        check("bp_alu_n_kept", 32'(bus.alu_n), 32'd20);
        check("bp_released",   32'(bus.cmd_ready), 32'd1);
        repeat (4) @(negedge clk);
        check("bp_no_extra", 32'(bus.rsp_valid), 32'd0);

        // zero flag forced wrong
        force_zer = 1'b1;
        issue(16'd8, 16'd3, OPC_0, 1'b0);
        wait_rsp(lat);
        check_rsp("fault", 16'd11, 1'b1, 1'b0, 1'b1);
        take_rsp();
        force_zer = 1'b0;
        check("fault_delivered", 32'(bus.rsp_valid), 32'd0);
`ifdef ALU_ISSUER_STATS_EN
        check("stat_ops_pre",  32'(stat_ops),  32'd5);
        check("stat_errs_pre", 32'(stat_errs), 32'd1);
`endif

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // random back-to-back operations
        for (int i = 0; i < 7; i++) begin
            n   = 16'($urandom);
            m   = 16'($urandom);
            c   = 1'($urandom);
            opc = 3'($urandom_range(1, 7));
            f   = alu_model(n, m, opc, c);
            issue(n, m, opc, c);
            wait_rsp(lat);
            check_rsp($sformatf("rand%0d", i), f, (f == 16'd0), f[15], 1'b0);
            take_rsp();
        end
`ifdef ALU_ISSUER_STATS_EN
        check("stat_ops",  32'(stat_ops),  32'd7);
        check("stat_errs", 32'(stat_errs), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
